sa_tile_scheduler: RTL and testbench

Sequences the systolic array through a full M×K by K×N matrix multiply once the top-level controller has loaded M, N and K and entered its streaming phase. It tiles the output into SA_ROWS×SA_COLS blocks and drives the single-port operand RAMs (ifmap, weight) and the ofmap RAM for each tile. It controls the array's clear, valid and drain timing, then returns a one-cycle `sa_done` to the top-level controller.

---
 rtl/accelerator_pkg.sv | 27 ++
 rtl/sa_addr_gen.sv | 42 ++++
 rtl/sa_tile_scheduler.sv | 121 ++++++++++++
 tb/tb_sa_tile_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/accelerator_pkg.sv
// accelerator_pkg: shared scheduler state encoding and systolic-array size defaults.
package accelerator_pkg;

    localparam int SA_ROWS_DEF = 4;
    localparam int SA_COLS_DEF = 4;

    localparam int ST_IDLE  = 0;
    localparam int ST_CHECK = 1;
    localparam int ST_CLEAR = 2;
    localparam int ST_FEED  = 3;
    localparam int ST_FLUSH = 4;
    localparam int ST_WRITE = 5;
    localparam int ST_NEXT  = 6;
    localparam int ST_DONE  = 7;

    typedef enum logic [7:0] {
        S_IDLE  = 8'b0000_0001,
        S_CHECK = 8'b0000_0010,
        S_CLEAR = 8'b0000_0100,
        S_FEED  = 8'b0000_1000,
        S_FLUSH = 8'b0001_0000,
        S_WRITE = 8'b0010_0000,
        S_NEXT  = 8'b0100_0000,
        S_DONE  = 8'b1000_0000
    } sa_sched_state_t;

endpackage

// File: rtl/sa_addr_gen.sv
// sa_addr_gen: incremental ifmap/weight operand addressing and the running ofmap write address.
module sa_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              k_clr,
    input  logic              k_step,
    input  logic              n_step,
    input  logic              n_wrap,
    input  logic              wr_step,
    input  logic [ADDR_W-1:0] k_inc,
    output logic [ADDR_W-1:0] ifmap_addr,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [ADDR_W-1:0] ofmap_addr
);

    logic [ADDR_W-1:0] i_base, w_base, k_off, o_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            i_base <= '0;
            w_base <= '0;
            k_off  <= '0;
            o_cnt  <= '0;
        end else begin
            k_off <= k_clr ? '0 : k_off + ADDR_W'(k_step);
            o_cnt <= o_cnt + ADDR_W'(wr_step);
            // n-tile wrap rewinds the weight base and moves to the next m-tile
            if (n_step) begin
                w_base <= n_wrap ? '0 : w_base + k_inc;
                i_base <= n_wrap ? i_base + k_inc : i_base;
            end
        end
    end

    assign ifmap_addr  = i_base + k_off;
    assign weight_addr = w_base + k_off;
    assign ofmap_addr  = o_cnt;

endmodule

// File: rtl/sa_tile_scheduler.sv
// sa_tile_scheduler: tiles an MxK by KxN multiply over the systolic array and sequences RAMs/array per tile.
// Optional busy-cycle counter on perf_cycles enabled by defining SA_SCHED_PERF_EN.
module sa_tile_scheduler
    import accelerator_pkg::*;
#(
    parameter int SA_ROWS = SA_ROWS_DEF,
    parameter int SA_COLS = SA_COLS_DEF,
    parameter int ADDR_W  = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [31:0]                M,
    input  logic [31:0]                N,
    input  logic [31:0]                K,
    output logic                       busy,
    output logic                       sa_done,
    output logic                       ifmap_cs,
    output logic                       weight_cs,
    output logic [ADDR_W-1:0]          ifmap_addr,
    output logic [ADDR_W-1:0]          weight_addr,
    output logic                       sa_clear,
    output logic                       sa_valid_in,
    output logic                       ofmap_we,
    output logic [ADDR_W-1:0]          ofmap_addr,
    output logic [$clog2(SA_ROWS)-1:0] ofmap_row,
    input  logic                       ofmap_ready,
    output logic [31:0]                perf_cycles
);

    localparam int          RLOG      = $clog2(SA_ROWS);
    localparam int          CLOG      = $clog2(SA_COLS);
    localparam logic [31:0] FLUSH_LEN = 32'(SA_ROWS + SA_COLS - 1);
    localparam logic [31:0] ROW_LAST  = 32'(SA_ROWS - 1);

    sa_sched_state_t state, nxt;
    logic [31:0] m_q, n_q, k_q, tm, tn, mt, nt, cnt;
    logic        acc, n_wrap, last, zero;

    assign acc    = state[ST_IDLE] && start;
    assign n_wrap = nt == tn - 1;
    assign last   = n_wrap && mt == tm - 1;
    assign zero   = m_q == 0 || n_q == 0 || k_q == 0;

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  nxt = start ? S_CHECK : S_IDLE;
            S_CHECK: nxt = zero ? S_DONE : S_CLEAR;
            S_CLEAR: nxt = S_FEED;
            S_FEED:  nxt = cnt == k_q - 1 ? S_FLUSH : S_FEED;
            S_FLUSH: nxt = cnt == FLUSH_LEN - 1 ? S_WRITE : S_FLUSH;
            S_WRITE: nxt = ofmap_ready && cnt == ROW_LAST ? S_NEXT : S_WRITE;
            S_NEXT:  nxt = last ? S_DONE : S_CLEAR;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            {m_q, n_q, k_q, tm, tn, mt, nt, cnt} <= '0;
            sa_valid_in <= 1'b0;
        end else begin
            sa_valid_in <= ifmap_cs;
            // cnt is the per-state step: k in FEED, skew in FLUSH, row in WRITE
            cnt <= nxt != state ? '0 :
                   cnt + 32'(state[ST_FEED] || state[ST_FLUSH] || (state[ST_WRITE] && ofmap_ready));
            if (acc) begin
                m_q <= M;
                n_q <= N;
                k_q <= K;
                tm  <= 32'(({1'b0, M} + 33'(SA_ROWS - 1)) >> RLOG);
                tn  <= 32'(({1'b0, N} + 33'(SA_COLS - 1)) >> CLOG);
                mt  <= '0;
                nt  <= '0;
            end else if (state[ST_NEXT]) begin
                nt <= n_wrap ? '0 : nt + 1;
                mt <= mt + 32'(n_wrap);
            end
        end
    end

    assign busy      = !state[ST_IDLE];
    assign sa_done   = state[ST_DONE];
    assign ifmap_cs  = state[ST_FEED];
    assign weight_cs = state[ST_FEED];
    assign sa_clear  = state[ST_CLEAR];
    assign ofmap_we  = state[ST_WRITE] && ofmap_ready;
    assign ofmap_row = state[ST_WRITE] ? cnt[RLOG-1:0] : '0;

    sa_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (acc),
        .k_clr      (state[ST_CLEAR]),
        .k_step     (state[ST_FEED]),
        .n_step     (state[ST_NEXT]),
        .n_wrap     (n_wrap),
        .wr_step    (ofmap_we),
        .k_inc      (k_q[ADDR_W-1:0]),
        .ifmap_addr (ifmap_addr),
        .weight_addr(weight_addr),
        .ofmap_addr (ofmap_addr)
    );

`ifdef SA_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn || acc) perf_cycles <= '0;
        else if (busy)    perf_cycles <= perf_cycles + 1;
    end
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// tb_sa_tile_scheduler: randomized and directed runs checked cycle-by-cycle against a tile-walk reference model.
module tb_sa_tile_scheduler;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 16;
    localparam int NC = 1024;

    logic          clk = 0, rstn = 0, start = 0, ofmap_ready = 1;
    logic [31:0]   M = 0, N = 0, K = 0;
    logic          busy, sa_done, ifmap_cs, weight_cs, sa_clear, sa_valid_in, ofmap_we;
    logic [AW-1:0] ifmap_addr, weight_addr, ofmap_addr;
    logic [1:0]    ofmap_row;
    logic [31:0]   perf_cycles;

    sa_tile_scheduler #(.SA_ROWS(R), .SA_COLS(C), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .M(M), .N(N), .K(K),
        .busy(busy), .sa_done(sa_done), .ifmap_cs(ifmap_cs), .weight_cs(weight_cs),
        .ifmap_addr(ifmap_addr), .weight_addr(weight_addr), .sa_clear(sa_clear),
        .sa_valid_in(sa_valid_in), .ofmap_we(ofmap_we), .ofmap_addr(ofmap_addr),
        .ofmap_row(ofmap_row), .ofmap_ready(ofmap_ready), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    bit e_busy[NC], e_cs[NC], e_clr[NC], e_val[NC], e_we[NC], e_wr[NC], e_done[NC], rdy[NC];
    int e_ia[NC], e_wa[NC], e_oa[NC], e_row[NC];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walks the tiles in order with plain cycle arithmetic; mode 0 always ready, 1 random ready, 2 fixed stall
    task automatic build(input int m, input int n, input int k, input int mode, output int td);
        int t, o, tm, tn;
        for (int i = 0; i < NC; i++) begin
            {e_busy[i], e_cs[i], e_clr[i], e_val[i], e_we[i], e_wr[i], e_done[i]} = '0;
            {e_ia[i], e_wa[i], e_oa[i], e_row[i]} = '0;
            rdy[i] = mode == 1 ? $urandom_range(0, 3) != 0 : !(mode == 2 && i >= 19 && i <= 21);
        end
        tm = (m + R - 1) / R;
        tn = (n + C - 1) / C;
        t = 2;
        o = 0;
        if (m != 0 && n != 0 && k != 0) begin
            for (int mt = 0; mt < tm; mt++)
                for (int nt = 0; nt < tn; nt++) begin
                    e_clr[t] = 1;
                    t++;
                    for (int kk = 0; kk < k; kk++) begin
                        e_cs[t] = 1;
                        e_ia[t] = (mt * k + kk) % 65536;
                        e_wa[t] = (nt * k + kk) % 65536;
                        e_val[t+1] = 1;
                        t++;
                    end
                    t += R + C - 1;
                    for (int r = 0; r < R; r++) begin
                        while (t < NC - 8 && !rdy[t]) begin
                            e_wr[t] = 1; e_row[t] = r; e_oa[t] = o; t++;
                        end
                        e_wr[t] = 1; e_we[t] = 1; e_row[t] = r; e_oa[t] = o;
                        o++; t++;
                    end
                    t++;
                end
        end
        e_done[t] = 1;
        for (int i = 1; i <= t; i++) e_busy[i] = 1;
        td = t;
    endtask

    task automatic check_cycle(input int c);
        check($sformatf("ctl@%0d", c),
              {busy, ifmap_cs, weight_cs, sa_clear, sa_valid_in, ofmap_we, sa_done},
              {e_busy[c], e_cs[c], e_cs[c], e_clr[c], e_val[c], e_we[c], e_done[c]});
        if (e_cs[c]) begin
            check($sformatf("ifmap_addr@%0d", c), ifmap_addr, e_ia[c]);
            check($sformatf("weight_addr@%0d", c), weight_addr, e_wa[c]);
        end
        if (e_wr[c]) begin
            check($sformatf("ofmap_addr@%0d", c), ofmap_addr, e_oa[c]);
            check($sformatf("ofmap_row@%0d", c), ofmap_row, e_row[c]);
        end
    endtask

    function automatic int perf_exp(input int td);
`ifdef SA_SCHED_PERF_EN
        return td;
`else
        return 0;
`endif
    endfunction

    task automatic idle_check(input string tag);
        check({tag, "_ctl"}, {busy, ifmap_cs, weight_cs, sa_clear, sa_valid_in, ofmap_we, sa_done}, 0);
        check({tag, "_addr"}, {ifmap_addr, weight_addr, ofmap_addr, ofmap_row}, 0);
        check({tag, "_perf"}, perf_cycles, 0);
    endtask

    task automatic launch(input int m, input int n, input int k);
        @(negedge clk);
        M = m; N = n; K = k;
        start = 1;
        ofmap_ready = 1;
    endtask

    task automatic run(input int m, input int n, input int k, input int mode, output int dc);
        int td;
        build(m, n, k, mode, td);
        launch(m, n, k);
        dc = -1;
        for (int c = 1; c <= td + 2; c++) begin
            @(negedge clk);
            // stray starts and dimension changes while busy must be ignored
            start = mode == 1 && c <= td && $urandom_range(0, 7) == 0;
            if (mode == 1) begin M = $urandom; N = $urandom; K = $urandom; end
            ofmap_ready = rdy[c];
            #1;
            check_cycle(c);
            if (sa_done && dc < 0) dc = c;
            if (c > td) check($sformatf("perf@%0d", c), perf_cycles, perf_exp(td));
        end
        start = 0;
        check("done_cyc", dc, td);
    endtask

    initial begin
        int dc, td, m, n, k;
        repeat (3) @(negedge clk);
        #1 idle_check("reset");
        rstn = 1;
        run(4, 4, 8, 0, dc);  check("single_done", dc, 23);
        run(5, 6, 3, 0, dc);  check("multi_done", dc, 66);
        run(4, 4, 0, 0, dc);  check("zero_done", dc, 2);
        run(4, 4, 8, 2, dc);  check("bp_done", dc, 26);
        build(4, 4, 4, 0, td);
        launch(4, 4, 4);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 0;
            #1 check_cycle(c);
        end
        rstn = 0;
        @(negedge clk);
        #1 idle_check("mid_reset");
        rstn = 1;
        run(4, 4, 4, 0, dc);  check("rerun_done", dc, 19);
        repeat (25) begin
            m = $urandom_range(1, 10); if ($urandom_range(0, 9) == 0) m = 0;
            n = $urandom_range(1, 10); if ($urandom_range(0, 9) == 0) n = 0;
            k = $urandom_range(0, 6);
            run(m, n, k, 1, dc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
